// File: rtl/rename_regfile_pkg.sv
// Shared constants for the rename register file.
// Widths and valid/enable encodings used by the top and read ports.
package rename_regfile_pkg;

    localparam int XLEN  = 32;
    localparam int TAG_W = 4;
    localparam int NREG  = 32;
    localparam int AW    = $clog2(NREG);

    localparam logic VALID   = 1'b1;
    localparam logic INVALID = 1'b0;
    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

endpackage

// File: rtl/rrf_read_port.sv
// Priority mux for one read port: flush, x0, commit bypass,
// CDB forwarding, then stored state.
module rrf_read_port
    import rename_regfile_pkg::*;
#(
    parameter int XLEN      = rename_regfile_pkg::XLEN,
    parameter int TAG_W     = rename_regfile_pkg::TAG_W,
    parameter int AW        = rename_regfile_pkg::AW,
    parameter int CM_PORTS  = 1,
    parameter int CDB_PORTS = 3
) (
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      re,
    input  logic [AW-1:0]             addr,
    input  logic                      st_valid,
    input  logic [TAG_W-1:0]          st_tag,
    input  logic [XLEN-1:0]           st_data,
    input  logic [CM_PORTS-1:0]       cm_en,
    input  logic [CM_PORTS*AW-1:0]    cm_addr,
    input  logic [CM_PORTS*TAG_W-1:0] cm_tag,
    input  logic [CM_PORTS*XLEN-1:0]  cm_data,
    input  logic [CDB_PORTS-1:0]      cdb_en,
    input  logic [CDB_PORTS*TAG_W-1:0] cdb_tag,
    input  logic [CDB_PORTS*XLEN-1:0] cdb_data,
    output logic                      valid,
    output logic [TAG_W-1:0]          tag,
    output logic [XLEN-1:0]           data
);

    logic            cm_hit;
    logic [XLEN-1:0] cm_val;
    logic            cdb_hit;
    logic [XLEN-1:0] cdb_val;

    always_comb begin
        cm_hit = 1'b0;
        cm_val = '0;
        for (int k = 0; k < CM_PORTS; k++) begin
            if (cm_en[k] == ENABLE && cm_addr[k*AW +: AW] == addr &&
                cm_tag[k*TAG_W +: TAG_W] == st_tag) begin
                cm_hit = 1'b1;
                cm_val = cm_data[k*XLEN +: XLEN];
            end
        end
        // Descending scan so the lowest matching CDB port ends up selected.
        cdb_hit = 1'b0;
        cdb_val = '0;
        for (int j = CDB_PORTS - 1; j >= 0; j--) begin
            if (cdb_en[j] == ENABLE && cdb_tag[j*TAG_W +: TAG_W] == st_tag) begin
                cdb_hit = 1'b1;
                cdb_val = cdb_data[j*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        valid = INVALID;
        tag   = '0;
        data  = '0;
        if (!rst_n || clear) begin
            valid = INVALID;
        end else if (!re) begin
            valid = INVALID;
        end else if (addr == '0) begin
            valid = VALID;
        end else if (cm_hit) begin
            valid = VALID;
            data  = cm_val;
        end else if (st_valid == INVALID && cdb_hit) begin
            valid = VALID;
            data  = cdb_val;
        end else begin
            valid = st_valid;
            tag   = st_tag;
            data  = st_data;
        end
    end

endmodule

// File: rtl/rename_regfile.sv
// Architectural register file with producer tags and valid bits,
// multi-port rename/commit and combinational CDB-forwarding reads.
module rename_regfile
    import rename_regfile_pkg::*;
#(
    parameter int NREG      = rename_regfile_pkg::NREG,
    parameter int XLEN      = rename_regfile_pkg::XLEN,
    parameter int TAG_W     = rename_regfile_pkg::TAG_W,
    parameter int RD_PORTS  = 2,
    parameter int REN_PORTS = 1,
    parameter int CM_PORTS  = 1,
    parameter int CDB_PORTS = 3,
    localparam int AW       = $clog2(NREG)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         rdy,
    input  logic                         clear,
    input  logic [RD_PORTS-1:0]          rd_re_i,
    input  logic [RD_PORTS*AW-1:0]       rd_addr_i,
    output logic [RD_PORTS-1:0]          rd_valid_o,
    output logic [RD_PORTS*TAG_W-1:0]    rd_tag_o,
    output logic [RD_PORTS*XLEN-1:0]     rd_data_o,
    input  logic [REN_PORTS-1:0]         rn_en_i,
    input  logic [REN_PORTS*AW-1:0]      rn_addr_i,
    input  logic [REN_PORTS*TAG_W-1:0]   rn_tag_i,
    input  logic [CM_PORTS-1:0]          cm_en_i,
    input  logic [CM_PORTS*AW-1:0]       cm_addr_i,
    input  logic [CM_PORTS*TAG_W-1:0]    cm_tag_i,
    input  logic [CM_PORTS*XLEN-1:0]     cm_data_i,
    input  logic [CDB_PORTS-1:0]         cdb_en_i,
    input  logic [CDB_PORTS*TAG_W-1:0]   cdb_tag_i,
    input  logic [CDB_PORTS*XLEN-1:0]    cdb_data_i
);

    logic [XLEN-1:0]  data_q  [NREG];
    logic [TAG_W-1:0] tag_q   [NREG];
    logic             valid_q [NREG];
    logic [XLEN-1:0]  data_d  [NREG];
    logic [TAG_W-1:0] tag_d   [NREG];
    logic             valid_d [NREG];
    logic             rn_hit;
    logic             cm_hit;

    // Ascending port scans give the younger (higher) port the last word.
    always_comb begin
        data_d  = data_q;
        tag_d   = tag_q;
        valid_d = valid_q;
        rn_hit  = 1'b0;
        cm_hit  = 1'b0;
        for (int r = 1; r < NREG; r++) begin
            rn_hit = 1'b0;
            cm_hit = 1'b0;
            for (int k = 0; k < CM_PORTS; k++) begin
                if (cm_en_i[k] == ENABLE && cm_addr_i[k*AW +: AW] == AW'(r)) begin
                    data_d[r] = cm_data_i[k*XLEN +: XLEN];
                    if (cm_tag_i[k*TAG_W +: TAG_W] == tag_q[r])
                        cm_hit = 1'b1;
                end
            end
            for (int k = 0; k < REN_PORTS; k++) begin
                if (rn_en_i[k] == ENABLE && rn_addr_i[k*AW +: AW] == AW'(r)) begin
                    rn_hit   = 1'b1;
                    tag_d[r] = rn_tag_i[k*TAG_W +: TAG_W];
                end
            end
            if (clear) begin
                tag_d[r]   = tag_q[r];
                valid_d[r] = VALID;
            end else if (rn_hit) begin
                valid_d[r] = INVALID;
            end else if (cm_hit) begin
                valid_d[r] = VALID;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                data_q[r]  <= '0;
                tag_q[r]   <= '0;
                valid_q[r] <= VALID;
            end
        end else if (rdy) begin
            data_q  <= data_d;
            tag_q   <= tag_d;
            valid_q <= valid_d;
        end
    end

    for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
        logic [AW-1:0] a;
        assign a = rd_addr_i[p*AW +: AW];

        rrf_read_port #(
            .XLEN      (XLEN),
            .TAG_W     (TAG_W),
            .AW        (AW),
            .CM_PORTS  (CM_PORTS),
            .CDB_PORTS (CDB_PORTS)
        ) u_port (
            .rst_n    (rst_n),
            .clear    (clear),
            .re       (rd_re_i[p]),
            .addr     (a),
            .st_valid (valid_q[a]),
            .st_tag   (tag_q[a]),
            .st_data  (data_q[a]),
            .cm_en    (cm_en_i),
            .cm_addr  (cm_addr_i),
            .cm_tag   (cm_tag_i),
            .cm_data  (cm_data_i),
            .cdb_en   (cdb_en_i),
            .cdb_tag  (cdb_tag_i),
            .cdb_data (cdb_data_i),
            .valid    (rd_valid_o[p]),
            .tag      (rd_tag_o[p*TAG_W +: TAG_W]),
            .data     (rd_data_o[p*XLEN +: XLEN])
        );
    end

endmodule

// File: tb/tb_rename_regfile.sv
// Directed and randomized checks of rename_regfile against
// an array-based reference model of register state.
module tb_rename_regfile;

    localparam int RP = 2, NP = 2, CP = 2, BP = 3;

    logic clk = 1'b0;
    logic rst_n, rdy, clear;

    logic        rd_re   [RP];
    logic [4:0]  rd_addr [RP];
    logic        rn_en   [NP];
    logic [4:0]  rn_addr [NP];
    logic [3:0]  rn_tag  [NP];
    logic        cm_en   [CP];
    logic [4:0]  cm_addr [CP];
    logic [3:0]  cm_tag  [CP];
    logic [31:0] cm_data [CP];
    logic        cdb_en  [BP];
    logic [3:0]  cdb_tag [BP];
    logic [31:0] cdb_data[BP];

    logic [RP-1:0]    rd_re_f;
    logic [RP*5-1:0]  rd_addr_f;
    logic [RP-1:0]    rd_valid_f;
    logic [RP*4-1:0]  rd_tag_f;
    logic [RP*32-1:0] rd_data_f;
    logic [NP-1:0]    rn_en_f;
    logic [NP*5-1:0]  rn_addr_f;
    logic [NP*4-1:0]  rn_tag_f;
    logic [CP-1:0]    cm_en_f;
    logic [CP*5-1:0]  cm_addr_f;
    logic [CP*4-1:0]  cm_tag_f;
    logic [CP*32-1:0] cm_data_f;
    logic [BP-1:0]    cdb_en_f;
    logic [BP*4-1:0]  cdb_tag_f;
    logic [BP*32-1:0] cdb_data_f;

    always_comb begin
        for (int i = 0; i < RP; i++) begin
            rd_re_f[i] = rd_re[i];
            rd_addr_f[i*5 +: 5] = rd_addr[i];
        end
        for (int i = 0; i < NP; i++) begin
            rn_en_f[i] = rn_en[i];
            rn_addr_f[i*5 +: 5] = rn_addr[i];
            rn_tag_f[i*4 +: 4] = rn_tag[i];
        end
        for (int i = 0; i < CP; i++) begin
            cm_en_f[i] = cm_en[i];
            cm_addr_f[i*5 +: 5] = cm_addr[i];
            cm_tag_f[i*4 +: 4] = cm_tag[i];
            cm_data_f[i*32 +: 32] = cm_data[i];
        end
        for (int i = 0; i < BP; i++) begin
            cdb_en_f[i] = cdb_en[i];
            cdb_tag_f[i*4 +: 4] = cdb_tag[i];
            cdb_data_f[i*32 +: 32] = cdb_data[i];
        end
    end

    rename_regfile #(
        .NREG(32), .XLEN(32), .TAG_W(4),
        .RD_PORTS(RP), .REN_PORTS(NP), .CM_PORTS(CP), .CDB_PORTS(BP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .clear(clear),
        .rd_re_i(rd_re_f), .rd_addr_i(rd_addr_f),
        .rd_valid_o(rd_valid_f), .rd_tag_o(rd_tag_f), .rd_data_o(rd_data_f),
        .rn_en_i(rn_en_f), .rn_addr_i(rn_addr_f), .rn_tag_i(rn_tag_f),
        .cm_en_i(cm_en_f), .cm_addr_i(cm_addr_f),
        .cm_tag_i(cm_tag_f), .cm_data_i(cm_data_f),
        .cdb_en_i(cdb_en_f), .cdb_tag_i(cdb_tag_f), .cdb_data_i(cdb_data_f)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [31:0] m_data  [32];
    logic [3:0]  m_tag   [32];
    logic        m_valid [32];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic idle();
        rdy = 1'b1;
        clear = 1'b0;
        for (int i = 0; i < RP; i++) begin rd_re[i] = 1'b0; rd_addr[i] = '0; end
        for (int i = 0; i < NP; i++) begin
            rn_en[i] = 1'b0; rn_addr[i] = '0; rn_tag[i] = '0;
        end
        for (int i = 0; i < CP; i++) begin
            cm_en[i] = 1'b0; cm_addr[i] = '0; cm_tag[i] = '0; cm_data[i] = '0;
        end
        for (int i = 0; i < BP; i++) begin
            cdb_en[i] = 1'b0; cdb_tag[i] = '0; cdb_data[i] = '0;
        end
    endtask

    function automatic void mread(input int p, output logic v,
                                  output logic [3:0] t, output logic [31:0] d);
        logic [4:0] a;
        logic hit;
        v = 1'b0; t = '0; d = '0;
        a = rd_addr[p];
        if (!rst_n || clear || !rd_re[p]) return;
        if (a == 0) begin v = 1'b1; return; end
        hit = 1'b0;
        for (int k = 0; k < CP; k++)
            if (cm_en[k] && cm_addr[k] == a && cm_tag[k] == m_tag[a]) begin
                hit = 1'b1; d = cm_data[k];
            end
        if (hit) begin v = 1'b1; return; end
        if (!m_valid[a])
            for (int j = 0; j < BP; j++)
                if (!hit && cdb_en[j] && cdb_tag[j] == m_tag[a]) begin
                    hit = 1'b1; d = cdb_data[j];
                end
        if (hit) begin v = 1'b1; return; end
        v = m_valid[a]; t = m_tag[a]; d = m_data[a];
    endfunction

    task automatic mupdate();
        logic [3:0] ntag [32];
        logic       nval [32];
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) begin
                m_data[r] = '0; m_tag[r] = '0; m_valid[r] = 1'b1;
            end
            return;
        end
        if (!rdy) return;
        ntag = m_tag;
        nval = m_valid;
        for (int r = 1; r < 32; r++) begin
            if (clear) begin
                nval[r] = 1'b1;
                continue;
            end
            for (int k = 0; k < CP; k++)
                if (cm_en[k] && cm_addr[k] == r && cm_tag[k] == m_tag[r]) nval[r] = 1'b1;
            for (int k = 0; k < NP; k++)
                if (rn_en[k] && rn_addr[k] == r) begin
                    ntag[r] = rn_tag[k]; nval[r] = 1'b0;
                end
        end
        for (int k = 0; k < CP; k++)
            if (cm_en[k] && cm_addr[k] != 0) m_data[cm_addr[k]] = cm_data[k];
        m_tag = ntag;
        m_valid = nval;
    endtask

    task automatic check_reads();
        logic v;
        logic [3:0] t;
        logic [31:0] d;
        for (int p = 0; p < RP; p++) begin
            mread(p, v, t, d);
            chk($sformatf("p%0d_valid", p), 64'(rd_valid_f[p]), 64'(v));
            chk($sformatf("p%0d_tag", p), 64'(rd_tag_f[p*4 +: 4]), 64'(t));
            chk($sformatf("p%0d_data", p), 64'(rd_data_f[p*32 +: 32]), 64'(d));
        end
    endtask

    task automatic step();
        #1 check_reads();
        @(posedge clk);
        mupdate();
        @(negedge clk);
    endtask

    task automatic rd(input int p, input logic [4:0] a);
        rd_re[p] = 1'b1;
        rd_addr[p] = a;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        rd(0, 5);
        @(negedge clk);
        #1 chk("rst_read_valid", 64'(rd_valid_f[0]), 64'd0);
        step();
        step();
        rst_n = 1'b1;

        rd(0, 5); rd(1, 0);
        #1 chk("x5_valid", 64'(rd_valid_f[0]), 64'd1);
        chk("x5_data", 64'(rd_data_f[31:0]), 64'd0);
        chk("x0_valid", 64'(rd_valid_f[1]), 64'd1);
        chk("x0_data", 64'(rd_data_f[63:32]), 64'd0);
        step();

        rn_en[0] = 1'b1; rn_addr[0] = 3; rn_tag[0] = 7;
        step();
        idle();
        cm_en[0] = 1'b1; cm_addr[0] = 3; cm_tag[0] = 7; cm_data[0] = 32'hDEAD;
        rd(0, 3);
        #1 chk("cm_fwd_valid", 64'(rd_valid_f[0]), 64'd1);
        chk("cm_fwd_data", 64'(rd_data_f[31:0]), 64'hDEAD);
        step();
        idle(); rd(0, 3);
        #1 chk("cm_st_valid", 64'(rd_valid_f[0]), 64'd1);
        chk("cm_st_data", 64'(rd_data_f[31:0]), 64'hDEAD);
        step();

        rn_en[0] = 1'b1; rn_addr[0] = 3; rn_tag[0] = 7;
        step();
        idle(); rd(0, 3);
        cdb_en[1] = 1'b1; cdb_tag[1] = 7; cdb_data[1] = 32'h1234;
        #1 chk("cdb_valid", 64'(rd_valid_f[0]), 64'd1);
        chk("cdb_data", 64'(rd_data_f[31:0]), 64'h1234);
        cdb_tag[1] = 6;
        #1 chk("cdb_miss_valid", 64'(rd_valid_f[0]), 64'd0);
        chk("cdb_miss_tag", 64'(rd_tag_f[3:0]), 64'd7);
        step();

        idle();
        rn_en[0] = 1'b1; rn_addr[0] = 4; rn_tag[0] = 2;
        step();
        rn_tag[0] = 5;
        step();
        idle();
        cm_en[0] = 1'b1; cm_addr[0] = 4; cm_tag[0] = 2; cm_data[0] = 32'h11;
        step();
        idle(); rd(0, 4);
        #1 chk("stale_valid", 64'(rd_valid_f[0]), 64'd0);
        chk("stale_tag", 64'(rd_tag_f[3:0]), 64'd5);
        chk("stale_data", 64'(rd_data_f[31:0]), 64'h11);
        step();

        idle();
        rn_en[0] = 1'b1; rn_addr[0] = 6; rn_tag[0] = 3;
        step();
        rn_tag[0] = 9;
        cm_en[0] = 1'b1; cm_addr[0] = 6; cm_tag[0] = 3; cm_data[0] = 32'h66;
        step();
        idle(); rd(0, 6);
        #1 chk("rn_cm_valid", 64'(rd_valid_f[0]), 64'd0);
        chk("rn_cm_tag", 64'(rd_tag_f[3:0]), 64'd9);
        chk("rn_cm_data", 64'(rd_data_f[31:0]), 64'h66);
        step();

        idle();
        rn_en[0] = 1'b1; rn_addr[0] = 8; rn_tag[0] = 1;
        step();
        idle();
        clear = 1'b1;
        cm_en[0] = 1'b1; cm_addr[0] = 9; cm_tag[0] = 0; cm_data[0] = 32'h99;
        rd(0, 9);
        #1 chk("clr_rd_valid", 64'(rd_valid_f[0]), 64'd0);
        chk("clr_rd_data", 64'(rd_data_f[31:0]), 64'd0);
        step();
        idle(); rd(0, 8); rd(1, 9);
        #1 chk("clr_x8_valid", 64'(rd_valid_f[0]), 64'd1);
        chk("clr_x9_valid", 64'(rd_valid_f[1]), 64'd1);
        chk("clr_x9_data", 64'(rd_data_f[63:32]), 64'h99);
        step();

        idle();
        rdy = 1'b0;
        rn_en[0] = 1'b1; rn_addr[0] = 10; rn_tag[0] = 4;
        cm_en[0] = 1'b1; cm_addr[0] = 10; cm_tag[0] = 0; cm_data[0] = 32'hAA;
        step();
        idle(); rd(0, 10);
        #1 chk("hold_valid", 64'(rd_valid_f[0]), 64'd1);
        chk("hold_tag", 64'(rd_tag_f[3:0]), 64'd0);
        chk("hold_data", 64'(rd_data_f[31:0]), 64'd0);
        step();

        for (int n = 0; n < 600; n++) begin
            idle();
            rst_n = ($urandom_range(0, 99) != 0);
            rdy = ($urandom_range(0, 9) != 0);
            clear = ($urandom_range(0, 19) == 0);
            for (int i = 0; i < RP; i++) begin
                rd_re[i] = ($urandom_range(0, 7) != 0);
                rd_addr[i] = 5'($urandom_range(0, 7));
            end
            for (int i = 0; i < NP; i++) begin
                rn_en[i] = ($urandom_range(0, 2) == 0);
                rn_addr[i] = 5'($urandom_range(0, 7));
                rn_tag[i] = 4'($urandom);
            end
            for (int i = 0; i < CP; i++) begin
                cm_en[i] = ($urandom_range(0, 2) == 0);
                cm_addr[i] = 5'($urandom_range(0, 7));
                cm_tag[i] = ($urandom_range(0, 2) != 0) ? m_tag[cm_addr[i]] : 4'($urandom);
                cm_data[i] = $urandom;
            end
            for (int i = 0; i < BP; i++) begin
                cdb_en[i] = ($urandom_range(0, 1) == 0);
                cdb_tag[i] = ($urandom_range(0, 1) == 0) ?
                             m_tag[$urandom_range(0, 7)] : 4'($urandom);
                cdb_data[i] = $urandom;
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
